// File: rtl/led_trail_pkg.sv
// led_trail_pkg: shared constants and helpers for the LED comet-tail PWM block.
//
// Contents:
//   NUM_LEDS      - number of LED channels driven by led_trail_pwm
//   full_scale()  - all-ones brightness level for a given PWM width
//   sat_sub()     - subtract that clamps at zero instead of wrapping
//   gamma_curve() - square-law brightness mapping, (lvl*lvl) >> bits
//
// All helpers work on 32-bit values. Callers truncate the result to their own
// width, which limits PWM widths to 16 bits so the square fits in 32 bits.
package led_trail_pkg;

    localparam int NUM_LEDS = 8;

    function automatic logic [31:0] full_scale(input int bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    // The product is formed at twice the level width and the low half is dropped.
    function automatic logic [31:0] gamma_curve(input logic [31:0] lvl, input int bits);
        return (lvl * lvl) >> bits;
    endfunction

endpackage

// File: rtl/trail_channel.sv
// trail_channel: one LED of the comet tail.
//
// Holds the brightness level of a single LED. A load sets the level to full
// scale, and a decay tick steps it down toward zero. The level is compared
// against the shared PWM counter to give a registered LED drive bit.
//
// Optional feature: define LED_TRAIL_GAMMA_EN to pass the level through a
// square-law curve before the compare. Without it, duty equals the level.
//
// Ports:
//   clk      in  1         system clock
//   reset    in  1         synchronous active-low reset
//   load     in  1         LED lit by the game this cycle; wins over tick
//   tick     in  1         decay tick from the shared prescaler
//   pwm_cnt  in  PWM_BITS  shared free-running PWM counter
//   led      out 1         registered, PWM-dimmed LED drive
module trail_channel
    import led_trail_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int DECAY_STEP = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    logic [PWM_BITS-1:0] lvl;
    logic [PWM_BITS-1:0] duty;

    always_comb begin
`ifdef LED_TRAIL_GAMMA_EN
        duty = PWM_BITS'(gamma_curve(32'(lvl), PWM_BITS));
`else
        duty = lvl;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lvl <= '0;
            led <= 1'b0;
        end else begin
            if (load) begin
                lvl <= PWM_BITS'(full_scale(PWM_BITS));
            end else if (tick) begin
                lvl <= PWM_BITS'(sat_sub(32'(lvl), 32'(DECAY_STEP)));
            end
            // A strict compare keeps duty 0 dark and full scale lit 2^N-1 of 2^N cycles.
            led <= load | (duty > pwm_cnt);
        end
    end

endmodule

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: fading "comet tail" driver for the scanning-lights game.
//
// Takes the game's LED vector and drives the board LEDs. An LED lit by the game
// is shown at full brightness. After the scanner moves on, that LED fades out
// in DECAY_STEP steps, with one step every DECAY_DIV enabled cycles. The fade
// is rendered by a shared free-running PWM counter.
//
// Optional feature: LED_TRAIL_GAMMA_EN selects a square-law brightness curve
// in each channel. Latency and reset behaviour do not change with this build.
//
// Ports:
//   clk       in  1         system clock
//   reset     in  1         synchronous active-low reset
//   enable    in  1         game enable; gates only the decay prescaler
//   leds_in   in  NUM_LEDS  LED vector from the game
//   leds_out  out NUM_LEDS  registered PWM-dimmed LED drive
module led_trail_pwm
    import led_trail_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int DECAY_DIV  = 50000,
    parameter int DECAY_STEP = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_LEDS-1:0] leds_in,
    output logic [NUM_LEDS-1:0] leds_out
);

    localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;

    // The PWM counter keeps running while enable is low, so frozen levels stay visible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign tick = enable && (div_cnt == DIV_W'(DECAY_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        trail_channel #(
            .PWM_BITS  (PWM_BITS),
            .DECAY_STEP(DECAY_STEP)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .load   (leds_in[i]),
            .tick   (tick),
            .pwm_cnt(pwm_cnt),
            .led    (leds_out[i])
        );
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
module tb_led_trail_pwm;

    localparam int PWM_BITS   = 4;
    localparam int DECAY_DIV  = 2;
    localparam int DECAY_STEP = 4;
    localparam int FULL       = (1 << PWM_BITS) - 1;
    localparam int PERIOD     = 1 << PWM_BITS;
`ifdef LED_TRAIL_GAMMA_EN
    localparam int FROZEN_DUTY = 3;
`else
    localparam int FROZEN_DUTY = 7;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] leds_in = 8'hFF;
    logic [7:0] leds_out;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b1;

    led_trail_pwm #(
        .PWM_BITS  (PWM_BITS),
        .DECAY_DIV (DECAY_DIV),
        .DECAY_STEP(DECAY_STEP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .leds_in (leds_in),
        .leds_out(leds_out)
    );

    always #5 clk = ~clk;

    // Behavioural model: brightness levels, tick counter and PWM phase as integers.
    int         lvl_m[8];
    int         pwm_m = 0;
    int         enabled_cycles = 0;
    logic [7:0] exp_out = 8'h00;

    function automatic int duty_m(input int l);
`ifdef LED_TRAIL_GAMMA_EN
        return (l * l) / PERIOD;
`else
        return l;
`endif
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            pwm_m = 0;
            enabled_cycles = 0;
            exp_out = 8'h00;
            foreach (lvl_m[i]) lvl_m[i] = 0;
        end else begin
            bit tk;
            for (int i = 0; i < 8; i++)
                exp_out[i] = leds_in[i] || (duty_m(lvl_m[i]) > pwm_m);
            tk = 1'b0;
            if (enable) begin
                enabled_cycles++;
                tk = (enabled_cycles % DECAY_DIV) == 0;
            end
            for (int i = 0; i < 8; i++) begin
                if (leds_in[i]) lvl_m[i] = FULL;
                else if (tk) lvl_m[i] = (lvl_m[i] > DECAY_STEP) ? lvl_m[i] - DECAY_STEP : 0;
            end
            pwm_m = (pwm_m + 1) % PERIOD;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock; outputs are compared against the model on the falling edge.
    task automatic step();
        @(negedge clk);
        if (cmp_en) begin
            checks++;
            if (leds_out !== exp_out) begin
                failures++;
                $display("FAIL leds_out_model: got %h expected %h at %0t", leds_out, exp_out, $time);
            end
        end
    endtask

    task automatic wait_lvl(input int ch, input int target, input string name);
        int n;
        n = 0;
        while (lvl_m[ch] != target && n < 40) begin
            step();
            n++;
        end
        if (lvl_m[ch] != target) begin
            failures++;
            $display("FAIL %s: timeout waiting for level %0d, have %0d", name, target, lvl_m[ch]);
        end
    endtask

    initial begin
        int seq[$];
        int last;
        int hi;

        // Reset held for 3 cycles with all inputs high.
        for (int k = 0; k < 3; k++) begin
            step();
            check("reset_out", int'(leds_out), 0);
        end
        reset = 1'b1;
        step();
        check("release_out", int'(leds_out), 'hFF);
        leds_in = 8'h00;
        enable = 1'b1;
        for (int k = 0; k < 12; k++) step();
        check("all_decayed_lvl0", lvl_m[0], 0);

        // Decay of a one-cycle pulse on LED 0.
        leds_in = 8'h01;
        step();
        leds_in = 8'h00;
        last = -1;
        for (int k = 0; k < 16; k++) begin
            if (lvl_m[0] != last) begin
                seq.push_back(lvl_m[0]);
                last = lvl_m[0];
            end
            step();
        end
        check("decay_len", seq.size(), 5);
        if (seq.size() == 5) begin
            check("decay_0", seq[0], 15);
            check("decay_1", seq[1], 11);
            check("decay_2", seq[2], 7);
            check("decay_3", seq[3], 3);
            check("decay_4", seq[4], 0);
        end
        hi = 0;
        for (int k = 0; k < PERIOD; k++) begin
            step();
            hi += int'(leds_out[0]);
        end
        check("dark_after_decay", hi, 0);

        // Freeze at level 7.
        leds_in = 8'h01;
        step();
        leds_in = 8'h00;
        wait_lvl(0, 7, "freeze_wait");
        enable = 1'b0;
        step();
        for (int w = 0; w < 4; w++) begin
            hi = 0;
            for (int k = 0; k < PERIOD; k++) begin
                step();
                hi += int'(leds_out[0]);
            end
            check("frozen_window_high", hi, FROZEN_DUTY);
        end
        check("frozen_lvl", lvl_m[0], 7);

        // Load held across ticks on LED 3.
        enable = 1'b1;
        leds_in = 8'h08;
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            check("collision_led3", int'(leds_out[3]), 1);
        end
        check("collision_lvl3", lvl_m[3], 15);
        leds_in = 8'h00;
        for (int k = 0; k < 12; k++) step();

        // Reset in the middle of a decay.
        leds_in = 8'h04;
        step();
        leds_in = 8'h00;
        wait_lvl(2, 11, "midreset_wait");
        reset = 1'b0;
        step();
        check("midreset_out", int'(leds_out), 0);
        check("midreset_lvl2", lvl_m[2], 0);
        check("midreset_pwm", pwm_m, 0);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) step();

        // Model still tracks a fresh load after reset.
        leds_in = 8'h80;
        step();
        leds_in = 8'h00;
        step();
        check("post_reset_load", int'(leds_out[7]), 1);
        for (int k = 0; k < 20; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream stage of the scanning-lights game: consumes the 8-bit one-hot LED vector and drives the physical LEDs with a fading "comet tail". Each LED lit by the game is shown at full brightness. Once the scanner moves on, that LED's brightness decays in steps and is rendered by a shared PWM counter. Sits between the game's `leds` output and the board LED pins, on the same clock and reset.

## Interface
- `PWM_BITS`, 8: width of PWM counter and per-LED brightness level; full scale = 2^PWM_BITS−1.
- `DECAY_DIV`, 50000: enabled clock cycles per decay tick; legal ≥1.
- `DECAY_STEP`, 32: brightness subtracted per decay tick; legal 1..2^PWM_BITS−1.

- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `enable` input 1: same enable as the game; gates the decay prescaler only.
- `leds_in` input 8: LED vector from the game; any bit pattern accepted.
- `leds_out` output 8: registered PWM-dimmed LED drive.

## Operation
- `pwm_cnt` (PWM_BITS): free-running, +1 every cycle regardless of `enable`, wraps from all-ones to 0.
- `div_cnt`: while `enable`=1, counts 0..DECAY_DIV−1 then wraps to 0. `tick` is asserted in the cycle `div_cnt`==DECAY_DIV−1 and `enable`=1. While `enable`=0, `div_cnt` holds.
- Per LED i, level `lvl[i]` (PWM_BITS):
  - `leds_in[i]`=1 → `lvl[i]` ← full scale. Load has priority over a simultaneous `tick`.
  - else `tick` → `lvl[i]` ← `lvl[i]`−DECAY_STEP, saturating at 0. No wrap-around.
  - else hold.
- Duty `duty[i]` = f(`lvl[i]`); see Configuration.
- `leds_out[i]` ← 1 if `leds_in[i]`=1, else (`duty[i]` > `pwm_cnt`).
  - Duty 0 → never on.
  - A decaying LED at full scale is on 2^PWM_BITS−1 of every 2^PWM_BITS cycles.
- Reset (`reset`=0 at an edge): `pwm_cnt`, `div_cnt`, all `lvl`, and `leds_out` ← 0. `leds_in` is ignored during reset.

## Timing
- Reset value of `leds_out`: 8'h00. It stays 0 during every cycle in which `reset`=0.
- Latency `leds_in` → `leds_out`: 1 clock. A bit rising at edge k is visible after edge k+1.
- Release of a bit: full-scale level decays on the first `tick` after the load cycle. The LED reaches 0 after ceil((2^PWM_BITS−1)/DECAY_STEP) ticks.
- Reset mid-decay: levels are cleared immediately and the trail is lost. `pwm_cnt` restarts at 0 on the first cycle after release.
- `enable`=0: the trail freezes at its current levels and PWM keeps rendering them.

## Configuration
- `LED_TRAIL_GAMMA_EN` defined: `duty[i]` = (`lvl[i]`·`lvl[i]`) >> PWM_BITS, a square-law perceptual curve. The product is computed at 2·PWM_BITS width and truncated. Example at PWM_BITS=8: 255→254, 128→64.
- Not defined: `duty[i]` = `lvl[i]`, a linear curve.
- `leds_out` latency and reset behaviour are identical in both builds.

## Structure
- Package `led_trail_pkg` holds:
  - `NUM_LEDS`=8.
  - The full-scale constant function of PWM_BITS.
  - The saturating-subtract and gamma helper functions.
- Sub-module `trail_channel`, instantiated 8× via generate. It holds one `lvl` register plus load/decay/duty/compare logic. Inputs: `clk`, `reset`, `load`, `tick`, `pwm_cnt`. Output: the registered LED bit.
- The top level owns `pwm_cnt`, `div_cnt`/`tick` and the instance array.

## Test plan
Unless noted, run with PWM_BITS=4, DECAY_DIV=2, DECAY_STEP=4, and no gamma.
- Reset: hold `reset`=0 for 3 cycles with `leds_in`=8'hFF → `leds_out`=8'h00 each cycle. Release → `leds_out`=8'hFF after the next edge.
- Decay: pulse `leds_in`=8'h01 for 1 cycle, `enable`=1 → `lvl[0]` follows 15, 11, 7, 3, 0, changing every 2 cycles.
  - The high-count of `leds_out[0]` over each 16-cycle window matches the current level.
  - After 0, `leds_out[0]` stays low.
- Freeze: decay to `lvl`=7, then `enable`=0 for 64 cycles → `lvl` stays 7 and `leds_out[0]` is high exactly 7 of every 16 cycles.
- Load/tick collision: hold `leds_in[3]`=1 across several `tick` cycles → `lvl[3]` stays 15 and `leds_out[3]` stays 1 continuously.
- Reset mid-decay: assert `reset`=0 for 1 cycle while `lvl[2]`=11 → `lvl[2]`=0, `pwm_cnt`=0 and `leds_out`=8'h00 after that edge.
- Gamma: build with `LED_TRAIL_GAMMA_EN` and freeze at `lvl`=7 → duty 3 (high 3 of every 16 cycles). The linear build gives 7.
